// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a time to
// instruction memory and holds a single fetched word until the decoder takes it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic        instrValid,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus8,
  input  logic        decodeStall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget
);

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus8_q, pc_plus8_d;
  logic        buf_free;
  logic        req;

  always_comb begin
    buf_free = !instr_valid_q || !decodeStall;
    req      = (state_q == ST_ISSUE) && buf_free && !branchTaken && !reset;
  end

  assign imemReq     = req;
  assign imemAddr    = req ? pc_q : 32'h0000_0000;
  assign instruction = instr_q;
  assign instrValid  = instr_valid_q;
  assign pcOut       = pc_out_q;
  assign pcPlus8     = pc_plus8_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_out_d      = pc_out_q;
    pc_plus8_d    = pc_plus8_q;

    if (instr_valid_q && !decodeStall) begin
      instr_valid_d = 1'b0;
    end

    if (branchTaken) begin
      // A redirect flushes the buffer; a response still owed by memory must be swallowed.
      pc_d          = branchTarget;
      instr_valid_d = 1'b0;
      case (state_q)
        ST_ISSUE: state_d = ST_ISSUE;
        ST_WAIT:  state_d = imemValid ? ST_ISSUE : ST_DROP;
        ST_DROP:  state_d = imemValid ? ST_ISSUE : ST_DROP;
        default:  state_d = ST_ISSUE;
      endcase
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (req) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imemValid) begin
            instr_d       = imemData;
            instr_valid_d = 1'b1;
            pc_out_d      = pc_q;
            pc_plus8_d    = pc_q + 32'd8;
            pc_d          = pc_q + PC_STEP;
            state_d       = ST_ISSUE;
          end
        end
        ST_DROP: begin
          if (imemValid) begin
            state_d = ST_ISSUE;
          end
        end
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ISSUE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      pc_out_q      <= 32'h0000_0000;
      pc_plus8_q    <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
      pc_plus8_q    <= pc_plus8_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table plus hand-written
// sequences for address wrap, mid-fetch reset and repeated redirects while dropping.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic        instrValid;
  logic [31:0] pcOut;
  logic [31:0] pcPlus8;
  logic        decodeStall;
  logic        branchTaken;
  logic [31:0] branchTarget;

  int tests  = 0;
  int failed = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemValid   (imemValid),
    .imemData    (imemData),
    .instruction (instruction),
    .instrValid  (instrValid),
    .pcOut       (pcOut),
    .pcPlus8     (pcPlus8),
    .decodeStall (decodeStall),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [31:0] idata;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc8;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] D0 = 32'hE08A_B00D;
  localparam logic [31:0] D1 = 32'hE23A_B0FF;
  localparam logic [31:0] D2 = 32'hE1A0_1002;
  localparam logic [31:0] D3 = 32'hDEAD_BEEF;
  localparam logic [31:0] D4 = 32'hE3A0_0001;
  localparam logic [31:0] D5 = 32'hE59F_1004;
  localparam logic [31:0] D7 = 32'hE1A0_F00E;
  localparam logic [31:0] BAD = 32'hBAD0_0BAD;
  localparam logic [31:0] Z = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic drive(input logic rst, input logic iv, input logic [31:0] idata,
                       input logic stall, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset = rst; imemValid = iv; imemData = idata;
    decodeStall = stall; branchTaken = br; branchTarget = tgt;
    #3;
  endtask

  initial begin
    reset = 1'b1; imemValid = 1'b0; imemData = Z;
    decodeStall = 1'b0; branchTaken = 1'b0; branchTarget = Z;

    //                 rst   iv    idata stall br    tgt            req   addr           valid instr pc_out         pc8
    tbl.push_back('{1'b1, 1'b0, Z,   1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  Z,             Z});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b1, 32'h0,         1'b0, Z,  Z,             Z});
    tbl.push_back('{1'b0, 1'b1, D0,  1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  Z,             Z});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b1, 32'h4,         1'b1, D0, 32'h0,         32'h8});
    tbl.push_back('{1'b0, 1'b1, D1,  1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D0, 32'h0,         32'h8});
    // buffer full and stalled for three cycles; a stray response in ISSUE is ignored
    tbl.push_back('{1'b0, 1'b0, Z,   1'b1, 1'b0, Z,             1'b0, Z,             1'b1, D1, 32'h4,         32'hC});
    tbl.push_back('{1'b0, 1'b1, BAD, 1'b1, 1'b0, Z,             1'b0, Z,             1'b1, D1, 32'h4,         32'hC});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b1, 1'b0, Z,             1'b0, Z,             1'b1, D1, 32'h4,         32'hC});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b1, 32'h8,         1'b1, D1, 32'h4,         32'hC});
    // three-cycle memory latency
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D1, 32'h4,         32'hC});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D1, 32'h4,         32'hC});
    tbl.push_back('{1'b0, 1'b1, D2,  1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D1, 32'h4,         32'hC});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b1, 32'hC,         1'b1, D2, 32'h8,         32'h10});
    // branch while waiting; the late response is dropped
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b1, 32'h100,       1'b0, Z,             1'b0, D2, 32'h8,         32'h10});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D2, 32'h8,         32'h10});
    tbl.push_back('{1'b0, 1'b1, D3,  1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D2, 32'h8,         32'h10});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b1, 32'h100,       1'b0, D2, 32'h8,         32'h10});
    tbl.push_back('{1'b0, 1'b1, D4,  1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D2, 32'h8,         32'h10});
    // branch with a full, stalled buffer
    tbl.push_back('{1'b0, 1'b0, Z,   1'b1, 1'b1, 32'h200,       1'b0, Z,             1'b1, D4, 32'h100,       32'h108});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b1, 1'b0, Z,             1'b1, 32'h200,       1'b0, D4, 32'h100,       32'h108});
    tbl.push_back('{1'b0, 1'b1, D5,  1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D4, 32'h100,       32'h108});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b1, 32'h204,       1'b1, D5, 32'h200,       32'h208});
    tbl.push_back('{1'b0, 1'b0, Z,   1'b0, 1'b0, Z,             1'b0, Z,             1'b0, D5, 32'h200,       32'h208});

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].idata, tbl[i].stall, tbl[i].br, tbl[i].tgt);
      $display("[TB] vec %0d: req=%0b addr=%h valid=%0b instr=%h pcOut=%h pcPlus8=%h",
               i, imemReq, imemAddr, instrValid, instruction, pcOut, pcPlus8);
      check($sformatf("vec%0d.req", i),    {31'b0, imemReq},    {31'b0, tbl[i].req});
      check($sformatf("vec%0d.addr", i),   imemAddr,            tbl[i].addr);
      check($sformatf("vec%0d.valid", i),  {31'b0, instrValid}, {31'b0, tbl[i].valid});
      check($sformatf("vec%0d.instr", i),  instruction,         tbl[i].instr);
      check($sformatf("vec%0d.pcOut", i),  pcOut,               tbl[i].pc_out);
      check($sformatf("vec%0d.pcPlus8", i), pcPlus8,            tbl[i].pc8);
    end

    // Redirect to the top of the address space, coinciding with the awaited response.
    drive(1'b0, 1'b1, BAD, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap.br_req", {31'b0, imemReq}, 32'h0);
    drive(1'b0, 1'b0, Z, 1'b0, 1'b0, Z);
    $display("[TB] wrap fetch: req=%0b addr=%h valid=%0b", imemReq, imemAddr, instrValid);
    check("wrap.req", {31'b0, imemReq}, 32'h1);
    check("wrap.addr", imemAddr, 32'hFFFF_FFFC);
    check("wrap.flushed", {31'b0, instrValid}, 32'h0);
    drive(1'b0, 1'b1, D7, 1'b0, 1'b0, Z);
    drive(1'b0, 1'b0, Z, 1'b0, 1'b0, Z);
    $display("[TB] wrap load: instr=%h pcOut=%h pcPlus8=%h next addr=%h", instruction, pcOut, pcPlus8, imemAddr);
    check("wrap.valid", {31'b0, instrValid}, 32'h1);
    check("wrap.instr", instruction, D7);
    check("wrap.pcOut", pcOut, 32'hFFFF_FFFC);
    check("wrap.pcPlus8", pcPlus8, 32'h4);
    check("wrap.next_req", {31'b0, imemReq}, 32'h1);
    check("wrap.next_addr", imemAddr, 32'h0);

    // Reset while a fetch is outstanding.
    drive(1'b1, 1'b0, Z, 1'b0, 1'b0, Z);
    check("rst.req_during", {31'b0, imemReq}, 32'h0);
    check("rst.addr_during", imemAddr, 32'h0);
    drive(1'b1, 1'b0, Z, 1'b0, 1'b0, Z);
    $display("[TB] mid-wait reset: valid=%0b instr=%h pcOut=%h pcPlus8=%h", instrValid, instruction, pcOut, pcPlus8);
    check("rst.valid", {31'b0, instrValid}, 32'h0);
    check("rst.instr", instruction, 32'h0);
    check("rst.pcOut", pcOut, 32'h0);
    check("rst.pcPlus8", pcPlus8, 32'h0);
    drive(1'b0, 1'b0, Z, 1'b0, 1'b0, Z);
    $display("[TB] restart: req=%0b addr=%h", imemReq, imemAddr);
    check("rst.restart_req", {31'b0, imemReq}, 32'h1);
    check("rst.restart_addr", imemAddr, 32'h0);

    // Two redirects while a dropped response is still owed; the last target wins.
    drive(1'b0, 1'b0, Z, 1'b0, 1'b1, 32'h300);
    check("drop.br1_req", {31'b0, imemReq}, 32'h0);
    drive(1'b0, 1'b0, Z, 1'b0, 1'b1, 32'h340);
    check("drop.br2_req", {31'b0, imemReq}, 32'h0);
    drive(1'b0, 1'b1, BAD, 1'b0, 1'b0, Z);
    check("drop.resp_req", {31'b0, imemReq}, 32'h0);
    drive(1'b0, 1'b0, Z, 1'b0, 1'b0, Z);
    $display("[TB] after drop: req=%0b addr=%h valid=%0b", imemReq, imemAddr, instrValid);
    check("drop.req", {31'b0, imemReq}, 32'h1);
    check("drop.addr", imemAddr, 32'h340);
    check("drop.valid", {31'b0, instrValid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the single-issue ARM-subset core; sits directly upstream of the decoder and feeds it one 32-bit instruction word (cond/type/I/opcode/S/Rn/Rd/operand layout) at a time. Owns the PC, issues requests to instruction memory over a valid handshake with variable latency, and buffers one fetched instruction until the decoder accepts it. Branch redirects from the execute/condition logic flush the buffer and discard any in-flight memory response.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imemReq  out  1  request strobe; memory accepts it in the same cycle.
- imemAddr  out  32  byte address of request; valid when imemReq=1.
- imemValid  in  1  one-cycle pulse with read data, ≥1 cycle after request.
- imemData  in  32  instruction word; sampled only when imemValid=1.
- instruction  out  32  buffered instruction to the decoder.
- instrValid  out  1  instruction buffer holds a valid word.
- pcOut  out  32  byte address of the buffered instruction.
- pcPlus8  out  32  pcOut + 8 (architectural R15 read value).
- decodeStall  in  1  decoder cannot accept the buffered word this cycle.
- branchTaken  in  1  redirect; highest priority after reset.
- branchTarget  in  32  redirect byte address.

## Operation
- States: ISSUE, WAIT, DROP. Reset: state=ISSUE, pc=RESET_PC, instrValid=0, instruction=0, pcOut=0, pcPlus8=0, imemReq=0 during the reset cycle, imemAddr=0 when imemReq=0.
- Buffer consumed in any cycle with instrValid=1 and decodeStall=0; then instrValid drops next cycle unless reloaded the same edge.
- bufFree = !instrValid || !decodeStall.
- imemReq = (state==ISSUE) && bufFree && !branchTaken && !reset; imemAddr = pc. On request: state→WAIT.
- ISSUE with !bufFree: hold, no request, buffer and pc unchanged.
- WAIT, imemValid=1, no branch: instruction<=imemData, pcOut<=pc, pcPlus8<=pc+8, instrValid<=1, pc<=pc+PC_STEP, state→ISSUE.
- WAIT, imemValid=0: hold; imemReq=0.
- branchTaken=1 (any state): pc<=branchTarget, instrValid<=0 (flush), no request that cycle. Next state: ISSUE if state was ISSUE, or WAIT with imemValid=1 (response discarded); DROP if WAIT with imemValid=0.
- DROP: imemReq=0; on imemValid discard data, state→ISSUE. Further branchTaken in DROP updates pc, stays DROP (or →ISSUE if imemValid same cycle).
- imemValid in ISSUE is ignored (protocol error, never loads buffer).
- At most one outstanding request at any time.
- Arithmetic: 32-bit wrap-around; pc=32'hFFFF_FFFC + 4 → 0; pcPlus8 wraps likewise.
- Reset mid-operation: returns to reset values regardless of state; instruction memory shares the same reset and cancels its outstanding response.

## Timing
- Reset released before edge 0: cycle 0 imemReq=1, imemAddr=RESET_PC.
- 1-cycle memory (imemValid in cycle after request): instrValid=1 two cycles after request; next request issued the same cycle the word is consumed. Sustained throughput with no stalls: one instruction per 2 cycles.
- N-cycle memory: instrValid rises N+1 cycles after request.
- Branch effect: first request to branchTarget one cycle after branchTaken (from ISSUE/WAIT-with-response), or one cycle after the discarded response (from DROP).
- Buffer outputs are registered; imemReq/imemAddr combinational from state, pc, instrValid, decodeStall, branchTaken.

## Test plan
- Reset, RESET_PC=0, 1-cycle memory returning 32'hE08A_B00D @0, 32'hE23A_B0FF @4 -> imemReq cycle 0 addr 0; instrValid cycle 2 instruction E08AB00D pcOut 0 pcPlus8 8; request addr 4 in cycle 2; second word valid cycle 4.
- decodeStall held 3 cycles with buffer full -> instruction/pcOut stable, imemReq=0 throughout; request issued the cycle decodeStall falls.
- 3-cycle memory latency -> instrValid rises 4 cycles after request; no second request while WAIT.
- branchTaken target 32'h0000_0100 in WAIT, response arrives 2 cycles later -> state DROP, data discarded, instrValid stays 0, next imemAddr=0x100.
- branchTaken with instrValid=1 and decodeStall=1 -> instrValid=0 next cycle, next request addr=branchTarget.
- pc=32'hFFFF_FFFC fetched -> pcPlus8=4, next imemAddr=0; reset asserted mid-WAIT -> all outputs zero, restart at RESET_PC.
